// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between fetch and data stages.
// Grants one requester at a time, runs a req/ready handshake with timeout, and drives pipeline stalls.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_done,
   input  logic          dm_read,
   input  logic          dm_write,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_done,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          stall_if,
   output logic          stall_pipe,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT, DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t        state, state_d;
   logic [7:0]    cnt, cnt_d;
   logic          last_dm, last_dm_d;
   logic          rd_zero, rd_zero_d;
   logic          mem_req_d, mem_we_d;
   logic [AW-1:0] mem_addr_d;
   logic [DW-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
   logic          if_done_d, dm_done_d, err_d;
   logic          dm_req, pick_dm;

   assign dm_req     = dm_read | dm_write;
   assign stall_pipe = dm_req & ~dm_done;
   assign stall_if   = stall_pipe | (if_req & ~if_done);

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      last_dm_d   = last_dm;
      rd_zero_d   = rd_zero;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      if_rdata_d  = if_rdata;
      dm_rdata_d  = dm_rdata;
      if_done_d   = 1'b0;
      dm_done_d   = 1'b0;
      err_d       = 1'b0;
      // DM wins a tie unless it also won the previous grant
      pick_dm     = dm_req & (~if_req | ~last_dm);
      case (state)
         IDLE: begin
            if (if_req | dm_req) begin
               last_dm_d = pick_dm;
               mem_req_d = 1'b1;
               cnt_d     = '0;
               if (pick_dm) begin
                  mem_we_d    = dm_write;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
                  rd_zero_d   = dm_read & dm_write;
                  state_d     = DM_WAIT;
               end else begin
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  rd_zero_d   = 1'b0;
                  state_d     = IF_WAIT;
               end
            end
         end
         IF_WAIT, DM_WAIT: begin
            if (mem_ready || cnt == CNT_LAST) begin
               mem_req_d = 1'b0;
               err_d     = ~mem_ready;
               state_d   = DONE;
               if (state == DM_WAIT) begin
                  dm_done_d  = 1'b1;
                  dm_rdata_d = (mem_ready && !rd_zero) ? mem_rdata : '0;
               end else begin
                  if_done_d  = 1'b1;
                  if_rdata_d = mem_ready ? mem_rdata : '0;
               end
            end else begin
               cnt_d = cnt + 8'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         last_dm   <= 1'b0;
         rd_zero   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_done   <= 1'b0;
         dm_done   <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         last_dm   <= last_dm_d;
         rd_zero   <= rd_zero_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         if_rdata  <= if_rdata_d;
         dm_rdata  <= dm_rdata_d;
         if_done   <= if_done_d;
         dm_done   <= dm_done_d;
         err       <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected accesses queued in grant order,
// checked when mem_req rises and when a done pulse appears.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, dm_read, dm_write;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_done, dm_done, mem_req, mem_we, stall_if, stall_pipe, err;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;

   typedef struct {
      bit          is_dm;
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
      bit          chk_rdata;
      logic [31:0] rdata;
      bit          err;
      int          burst;
      bit          chk_gap;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          lat_cfg = 1;
   logic [31:0] rdata_cfg = 32'h0;
   bit          hold_if = 1'b0;
   int          wait_cnt = 0, burst = 0, cyc = 0, last_done_cyc = 0;
   bit          prev_req = 1'b0, prev_done = 1'b0;

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_pipe(stall_pipe), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", tag, act, exp);
      end
   endtask

   task automatic push(input bit is_dm, input logic [31:0] addr, input bit we,
                       input logic [31:0] wdata, input bit chk_rdata, input logic [31:0] rdata,
                       input bit e_err, input int e_burst, input bit chk_gap);
      exp_t e;
      e.is_dm = is_dm; e.addr = addr; e.we = we; e.wdata = wdata;
      e.chk_rdata = chk_rdata; e.rdata = rdata; e.err = e_err;
      e.burst = e_burst; e.chk_gap = chk_gap;
      q.push_back(e);
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("wait_budget", q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // memory model, monitor and requester release, all on the falling edge
   always @(negedge clk) begin
      exp_t e;
      logic exp_pipe;
      cyc++;
      if (mem_req) begin
         wait_cnt++;
         mem_ready = (lat_cfg != 0) && (wait_cnt == lat_cfg);
         mem_rdata = mem_ready ? rdata_cfg : 32'h0BAD0BAD;
      end else begin
         wait_cnt  = 0;
         mem_ready = 1'b0;
      end

      if (mem_req && !prev_req) begin
         burst = 1;
         if (q.size() == 0) check("spurious_req", 32'd1, 32'd0);
         else begin
            e = q[0];
            check("req_addr", mem_addr, e.addr);
            check("req_we", mem_we, e.we);
            if (e.we) check("req_wdata", mem_wdata, e.wdata);
            if (e.chk_gap) check("regrant_gap", 32'(cyc - last_done_cyc), 32'd2);
         end
      end else if (mem_req) burst++;

      if (prev_done) begin
         check("no_grant_in_done", mem_req, 1'b0);
         check("done_width", if_done | dm_done, 1'b0);
      end

      exp_pipe = (dm_read | dm_write) & ~dm_done;
      check("stall_pipe", stall_pipe, exp_pipe);
      check("stall_if", stall_if, exp_pipe | (if_req & ~if_done));
      check("err_without_done", err & ~(if_done | dm_done), 1'b0);

      if (if_done || dm_done) begin
         if (q.size() == 0) check("spurious_done", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            check("done_port_dm", dm_done, e.is_dm);
            check("done_port_if", if_done, !e.is_dm);
            if (e.chk_rdata) check(e.is_dm ? "dm_rdata" : "if_rdata",
                                   e.is_dm ? dm_rdata : if_rdata, e.rdata);
            check("err", err, e.err);
            check("req_burst", 32'(burst), 32'(e.burst));
         end
         last_done_cyc = cyc;
         if (dm_done) begin
            dm_read  = 1'b0;
            dm_write = 1'b0;
         end
         if (if_done && !hold_if) if_req = 1'b0;
      end
      prev_done = if_done | dm_done;
      prev_req  = mem_req;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst_n = 1'b0;
      if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_dm_rdata", dm_rdata, 32'h0);
      check("rst_dones", {if_done, dm_done, err}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // fetch only, ready on third wait cycle
      lat_cfg = 3; rdata_cfg = 32'h2008000A;
      push(1'b0, 32'h00400000, 1'b0, '0, 1'b1, 32'h2008000A, 1'b0, 3, 1'b0);
      if_addr = 32'h00400000; if_req = 1'b1;
      wait_empty(50);

      // simultaneous store and fetch: DM first, then IF
      lat_cfg = 2; rdata_cfg = 32'h8C0A0004;
      push(1'b1, 32'h10010004, 1'b1, 32'hDEADBEEF, 1'b0, '0, 1'b0, 2, 1'b0);
      push(1'b0, 32'h00400004, 1'b0, '0, 1'b1, 32'h8C0A0004, 1'b0, 2, 1'b1);
      dm_addr = 32'h10010004; dm_wdata = 32'hDEADBEEF; dm_write = 1'b1;
      if_addr = 32'h00400004; if_req = 1'b1;
      wait_empty(50);

      // load with immediate ready
      lat_cfg = 1; rdata_cfg = 32'h12345678;
      push(1'b1, 32'h10010000, 1'b0, '0, 1'b1, 32'h12345678, 1'b0, 1, 1'b0);
      dm_addr = 32'h10010000; dm_read = 1'b1;
      wait_empty(50);

      // pair after a DM grant: IF first; DM read+write acts as write with zero rdata
      lat_cfg = 1; rdata_cfg = 32'hA5A50001;
      push(1'b0, 32'h00400008, 1'b0, '0, 1'b1, 32'hA5A50001, 1'b0, 1, 1'b0);
      push(1'b1, 32'h10010010, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 1, 1'b1);
      dm_addr = 32'h10010010; dm_wdata = 32'hCAFEF00D; dm_read = 1'b1; dm_write = 1'b1;
      if_addr = 32'h00400008; if_req = 1'b1;
      wait_empty(50);

      // timeout: never ready
      lat_cfg = 0; rdata_cfg = 32'h55555555;
      push(1'b1, 32'h10010008, 1'b0, '0, 1'b1, 32'h0, 1'b1, 4, 1'b0);
      dm_addr = 32'h10010008; dm_read = 1'b1;
      wait_empty(50);

      // fetch held through DONE: re-grant exactly at the IDLE edge
      lat_cfg = 1; rdata_cfg = 32'h11112222;
      push(1'b0, 32'h0040000C, 1'b0, '0, 1'b1, 32'h11112222, 1'b0, 1, 1'b0);
      push(1'b0, 32'h0040000C, 1'b0, '0, 1'b1, 32'h11112222, 1'b0, 1, 1'b1);
      hold_if = 1'b1;
      if_addr = 32'h0040000C; if_req = 1'b1;
      begin
         int n = 0;
         while (q.size() != 1 && n < 50) begin
            @(posedge clk);
            n++;
         end
      end
      hold_if = 1'b0;
      wait_empty(50);

      // reset during DM_WAIT, then a clean fetch
      lat_cfg = 0;
      push(1'b1, 32'h1001000C, 1'b0, '0, 1'b0, '0, 1'b0, 0, 1'b0);
      dm_addr = 32'h1001000C; dm_read = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset_req", mem_req, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset_req", mem_req, 1'b0);
      q.delete();
      dm_read = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("post_reset_quiet", {if_done, dm_done, err}, 32'h0);
      lat_cfg = 2; rdata_cfg = 32'h0BADF00D;
      push(1'b0, 32'h00400010, 1'b0, '0, 1'b1, 32'h0BADF00D, 1'b0, 2, 1'b0);
      if_addr = 32'h00400010; if_req = 1'b1;
      wait_empty(50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
